// File: rtl/selen_wb_arbiter_pkg.sv
// Shared encodings and defaults for the two-master Wishbone arbiter.
// Widths mirror the core-wide address/data width defines.
package selen_wb_arbiter_pkg;

    localparam int CORE_ADDR_WIDTH = 32;
    localparam int CORE_DATA_WIDTH = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    localparam int ARB_TIMEOUT_DEFAULT = 255;
    localparam int ARB_CW_DEFAULT      = 8;

    function automatic logic [1:0] arb_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/selen_wb_wdog.sv
// Bus watchdog: counts unterminated strobe cycles and flags expiry on the
// cycle the count reaches TIMEOUT-1 without a slave termination.
module selen_wb_wdog
    import selen_wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int CW      = ARB_CW_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic term_i,
    output logic expire_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = active_i && !term_i && (cnt_q == CW'(TIMEOUT - 1));

    // Expiry clears too, so a master that keeps strobing gets a full new window.
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || term_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/selen_wb_arbiter.sv
// Two-master, one-slave Wishbone B4 classic arbiter with round-robin grant,
// bus lock for the duration of CYC and a watchdog that answers stalls with ERR.
module selen_wb_arbiter
    import selen_wb_arbiter_pkg::*;
#(
    parameter int AW      = CORE_ADDR_WIDTH,
    parameter int DW      = CORE_DATA_WIDTH,
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int CW      = ARB_CW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_stb_i,
    input  logic            m0_cyc_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_stb_i,
    input  logic            m1_cyc_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    arb_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       last_q, last_d;

    logic [AW-1:0]   m_adr [2];
    logic [DW-1:0]   m_dat [2];
    logic            m_we  [2];
    logic [DW/8-1:0] m_sel [2];
    logic            m_stb [2];
    logic            m_cyc [2];
    logic            m_ack [2];
    logic            m_err [2];
    logic            m_rty [2];

    assign m_adr[0] = m0_adr_i;  assign m_adr[1] = m1_adr_i;
    assign m_dat[0] = m0_dat_i;  assign m_dat[1] = m1_dat_i;
    assign m_we[0]  = m0_we_i;   assign m_we[1]  = m1_we_i;
    assign m_sel[0] = m0_sel_i;  assign m_sel[1] = m1_sel_i;
    assign m_stb[0] = m0_stb_i;  assign m_stb[1] = m1_stb_i;
    assign m_cyc[0] = m0_cyc_i;  assign m_cyc[1] = m1_cyc_i;

    logic busy;
    logic gidx;
    logic cyc_g;
    logic stb_g;
    logic term;
    logic expire;

    assign busy  = (state_q == ARB_BUSY);
    assign gidx  = gnt_q[1];
    assign cyc_g = m_cyc[gidx];
    assign stb_g = m_stb[gidx];
    assign term  = s_ack_i || s_err_i || s_rty_i;

    selen_wb_wdog #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .active_i (busy && cyc_g && stb_g),
        .term_i   (term),
        .expire_o (expire)
    );

    assign timeout_o = expire;
    assign gnt_o     = gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = ARB_BUSY;
                    gnt_d   = arb_onehot((last_q == ARB_M0) ? ARB_M1 : ARB_M0);
                end else if (m0_cyc_i) begin
                    state_d = ARB_BUSY;
                    gnt_d   = arb_onehot(ARB_M0);
                end else if (m1_cyc_i) begin
                    state_d = ARB_BUSY;
                    gnt_d   = arb_onehot(ARB_M1);
                end
            end
            ARB_BUSY: begin
                if (!cyc_g) begin
                    state_d = ARB_IDLE;
                    gnt_d   = 2'b00;
                    last_d  = gidx;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // Reset parks last on m1 so m0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= ARB_M1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        if (busy) begin
            s_adr_o = m_adr[gidx];
            s_dat_o = m_dat[gidx];
            s_we_o  = m_we[gidx];
            s_sel_o = m_sel[gidx];
            s_stb_o = stb_g && !expire;
            s_cyc_o = cyc_g;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign m_ack[gi] = busy && gnt_q[gi] && s_ack_i;
            assign m_err[gi] = busy && gnt_q[gi] && (s_err_i || expire);
            assign m_rty[gi] = busy && gnt_q[gi] && s_rty_i;
        end
    endgenerate

    assign m0_ack_o = m_ack[0];
    assign m0_err_o = m_err[0];
    assign m0_rty_o = m_rty[0];
    assign m1_ack_o = m_ack[1];
    assign m1_err_o = m_err[1];
    assign m1_rty_o = m_rty[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_selen_wb_arbiter.sv
// Directed bench for selen_wb_arbiter: single read, round-robin ties, lock,
// watchdog expiry, ack/expiry collision and asynchronous reset mid-cycle.
module tb_selen_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic          m0_we_i, m1_we_i, s_we_o;
    logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
    logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_rty_i;
    logic [1:0]    gnt_o;
    logic          timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    selen_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i),
        .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
        .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_rty_i(s_rty_i),
        .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_sel_i = 0; m0_stb_i = 0; m0_cyc_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = 0; m1_stb_i = 0; m1_cyc_i = 0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        #2;
        check_eq("rst_gnt", gnt_o, 2'b00);
        check_eq("rst_scyc", s_cyc_o, 0);
        check_eq("rst_sstb", s_stb_o, 0);
        check_eq("rst_timeout", timeout_o, 0);
        check_eq("rst_resp", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 6'b0);
        step();
        rst = 1'b0;
        step();

        // Single read
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h2000; m0_sel_i = 4'hF;
        settle();
        check_eq("rd_c0_scyc", s_cyc_o, 0);
        check_eq("rd_c0_gnt", gnt_o, 2'b00);
        step();
        settle();
        check_eq("rd_c1_scyc", s_cyc_o, 1);
        check_eq("rd_c1_gnt", gnt_o, 2'b01);
        check_eq("rd_c1_adr", s_adr_o, 32'h2000);
        check_eq("rd_c1_ack", m0_ack_o, 0);
        step();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        settle();
        check_eq("rd_c2_ack", m0_ack_o, 1);
        check_eq("rd_c2_dat", m0_dat_o, 32'hDEAD_BEEF);
        check_eq("rd_c2_m1ack", m1_ack_o, 0);
        step();
        idle_all();
        settle();
        check_eq("rd_c3_scyc", s_cyc_o, 0);
        step();
        settle();
        check_eq("rd_idle_gnt", gnt_o, 2'b00);
        $display("txn single_read adr=2000 dat=%08h", m0_dat_o);

        // Round-robin ties out of reset
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h10;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h20;
        step();
        s_ack_i = 1;
        settle();
        check_eq("rr_first_gnt", gnt_o, 2'b01);
        check_eq("rr_first_m0ack", m0_ack_o, 1);
        check_eq("rr_first_m1ack", m1_ack_o, 0);
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        settle();
        check_eq("rr_gap_gnt", gnt_o, 2'b00);
        check_eq("rr_gap_scyc", s_cyc_o, 0);
        step();
        settle();
        check_eq("rr_second_gnt", gnt_o, 2'b10);
        check_eq("rr_second_adr", s_adr_o, 32'h20);
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        settle();
        check_eq("rr_held_m0ack", m0_ack_o, 0);
        check_eq("rr_held_m1ack", m1_ack_o, 1);
        step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        m1_cyc_i = 1; m1_stb_i = 1;
        settle();
        check_eq("rr_gap2_gnt", gnt_o, 2'b00);
        step();
        settle();
        check_eq("rr_third_gnt", gnt_o, 2'b01);
        $display("txn round_robin grants 01,10,01");
        idle_all();
        step();
        step();

        // Lock during a 4-write burst
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h100; m0_dat_i = 32'hA0;
        step();
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h900; m1_dat_i = 32'h55;
        for (int k = 0; k < 4; k++) begin
            m0_adr_i = 32'h100 + 32'(4 * k);
            m0_dat_i = 32'hA0 + 32'(k);
            s_ack_i = 1;
            settle();
            check_eq($sformatf("lock_gnt%0d", k), gnt_o, 2'b01);
            check_eq($sformatf("lock_adr%0d", k), s_adr_o, 32'h100 + 32'(4 * k));
            check_eq($sformatf("lock_dat%0d", k), s_dat_o, 32'hA0 + 32'(k));
            check_eq($sformatf("lock_we_sel%0d", k), {s_we_o, s_sel_o}, 5'h1F);
            check_eq($sformatf("lock_ack%0d", k), {m0_ack_o, m1_ack_o}, 2'b10);
            step();
        end
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        step();
        settle();
        check_eq("lock_gap_gnt", gnt_o, 2'b00);
        step();
        settle();
        check_eq("lock_m1_gnt", gnt_o, 2'b10);
        check_eq("lock_m1_adr", s_adr_o, 32'h900);
        $display("txn lock_burst 4 writes then m1 granted");
        idle_all();
        step();
        step();

        // Watchdog expiry on the 8th strobe cycle
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hFFFF_0000;
        step();
        for (int k = 1; k <= 8; k++) begin
            settle();
            check_eq($sformatf("to_err%0d", k), m0_err_o, (k == 8));
            check_eq($sformatf("to_pulse%0d", k), timeout_o, (k == 8));
            check_eq($sformatf("to_stb%0d", k), s_stb_o, (k != 8));
            check_eq($sformatf("to_ack%0d", k), m0_ack_o, 0);
            step();
        end
        idle_all();
        $display("txn timeout m0 err on cycle 8");
        step();
        step();

        // Ack arriving on the expiry cycle wins
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000;
        step();
        for (int k = 1; k <= 8; k++) begin
            s_ack_i = (k == 8);
            settle();
            check_eq($sformatf("col_pulse%0d", k), timeout_o, 0);
            check_eq($sformatf("col_err%0d", k), m0_err_o, 0);
            if (k == 8) begin
                check_eq("col_ack", m0_ack_o, 1);
                check_eq("col_stb", s_stb_o, 1);
            end
            step();
        end
        idle_all();
        $display("txn collision ack wins on cycle 8");
        step();
        step();

        // Asynchronous reset mid-transaction
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h4000;
        step();
        step();
        step();
        step();
        settle();
        check_eq("ar_pre_scyc", s_cyc_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_scyc", s_cyc_o, 0);
        check_eq("ar_gnt", gnt_o, 2'b00);
        check_eq("ar_resp", {m0_ack_o, m0_err_o, m0_rty_o}, 3'b0);
        idle_all();
        #1;
        rst = 1'b0;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h5000;
        step();
        for (int k = 1; k <= 8; k++) begin
            settle();
            if (k == 1) begin
                check_eq("ar_m1_gnt", gnt_o, 2'b10);
                check_eq("ar_m1_scyc", s_cyc_o, 1);
            end
            check_eq($sformatf("ar_to_pulse%0d", k), timeout_o, (k == 8));
            check_eq($sformatf("ar_to_err%0d", k), {m0_err_o, m1_err_o}, (k == 8) ? 2'b01 : 2'b00);
            step();
        end
        idle_all();
        $display("txn async_reset then m1 grant and fresh watchdog");
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
